// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
// The control-field bit indices follow the one-hot encodings produced by Execute.
package mem_pkg;

  localparam int DW = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam int LD_LB  = 0;
  localparam int LD_LH  = 1;
  localparam int LD_LW  = 2;
  localparam int LD_LBU = 3;
  localparam int LD_LHU = 4;

  localparam int ST_SB = 0;
  localparam int ST_SH = 1;
  localparam int ST_SW = 2;

  typedef struct packed {
    logic          memread;
    logic          memwrite;
    logic          regwrite;
    logic [4:0]    rd;
    logic [DW-1:0] alures;
    logic [DW-1:0] rs2;
    logic [4:0]    ld;
    logic [2:0]    st;
  } exmem_t;

  function automatic logic is_misaligned(input logic [4:0] ld, input logic [2:0] st,
                                         input logic [1:0] a);
    return ((ld[LD_LH] | ld[LD_LHU]) & a[0]) |
           (ld[LD_LW] & (a != 2'b00)) |
           (st[ST_SH] & a[0]) |
           (st[ST_SW] & (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Request/acknowledge data-memory port between the MEM stage and RAM/MMIO.
interface mem_access_stage_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      be;
  logic [XLEN-1:0] rdata;
  logic            ack;

  modport master (output req, we, addr, wdata, be, input rdata, ack);
  modport slave  (input req, we, addr, wdata, be, output rdata, ack);
endinterface

// File: rtl/lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, and
// load lane extraction with sign or zero extension.
module lane_align
  import mem_pkg::*;
(
  input  logic [1:0]    i_a_lo,
  input  logic          i_memread,
  input  logic          i_memwrite,
  input  logic [4:0]    i_loadcntrl,
  input  logic [2:0]    i_storecntrl,
  input  logic [DW-1:0] i_rs2,
  input  logic [DW-1:0] i_rdata,
  output logic [3:0]    o_be,
  output logic [DW-1:0] o_wdata,
  output logic [DW-1:0] o_load_val
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store lane enables and replicated write data; loads always read the full word.
  always_comb begin
    o_be    = 4'b0000;
    o_wdata = i_rs2;
    if (i_memread) begin
      o_be = 4'hF;
    end else if (i_memwrite & i_storecntrl[ST_SB]) begin
      o_be    = 4'b0001 << i_a_lo;
      o_wdata = {(DW/8){i_rs2[7:0]}};
    end else if (i_memwrite & i_storecntrl[ST_SH]) begin
      o_be    = i_a_lo[1] ? 4'b1100 : 4'b0011;
      o_wdata = {(DW/16){i_rs2[15:0]}};
    end else if (i_memwrite & i_storecntrl[ST_SW]) begin
      o_be    = 4'hF;
      o_wdata = i_rs2;
    end else begin
      o_be    = 4'b0000;
      o_wdata = i_rs2;
    end
  end

  // Load lane selection and extension.
  always_comb begin
    case (i_a_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_a_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    if (i_loadcntrl[LD_LB]) begin
      o_load_val = {{(DW-8){w_byte[7]}}, w_byte};
    end else if (i_loadcntrl[LD_LBU]) begin
      o_load_val = {{(DW-8){1'b0}}, w_byte};
    end else if (i_loadcntrl[LD_LH]) begin
      o_load_val = {{(DW-16){w_half[15]}}, w_half};
    end else if (i_loadcntrl[LD_LHU]) begin
      o_load_val = {{(DW-16){1'b0}}, w_half};
    end else begin
      o_load_val = i_rdata;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues loads/stores on a req/ack port, stalls the front
// of the pipe while a transaction is outstanding, and builds the MEM/WB set.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_dbg,
  input  logic            i_ex_mem_memread,
  input  logic            i_ex_mem_memwrite,
  input  logic            i_ex_mem_regwrite,
  input  logic [4:0]      i_ex_mem_rd,
  input  logic [XLEN-1:0] i_ex_mem_alures,
  input  logic [XLEN-1:0] i_ex_mem_dout_rs2,
  input  logic [4:0]      i_ex_mem_loadcntrl,
  input  logic [2:0]      i_ex_mem_storecntrl,
  mem_access_stage_if.master bus,
  output logic            o_mem_hold,
  output logic [4:0]      o_mem_wb_rd,
  output logic            o_mem_wb_regwrite,
  output logic            o_mem_wb_memread,
  output logic [XLEN-1:0] o_wb_res,
  output logic            o_misalign_err,
  output logic            o_bus_err
);

  localparam int             CW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]  C_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0]  C_ONE  = CW'(1);

  mem_state_t      r_state;
  logic [CW-1:0]   r_cnt;
  exmem_t          r_snap;
  exmem_t          w_in;
  exmem_t          w_cur;
  logic            w_access, w_misalign, w_start, w_misfire;
  logic            w_done, w_timeout, w_hold, w_req;
  logic [3:0]      w_be;
  logic [DW-1:0]   w_wdata, w_load_val;
  logic [4:0]      r_rd;
  logic            r_regwrite, r_memread, r_misalign_err, r_bus_err;
  logic [XLEN-1:0] r_wb_res;

  assign w_in = {i_ex_mem_memread, i_ex_mem_memwrite, i_ex_mem_regwrite, i_ex_mem_rd,
                 i_ex_mem_alures, i_ex_mem_dout_rs2, i_ex_mem_loadcntrl, i_ex_mem_storecntrl};

  // In WAIT the bus is driven from the captured request so it stays stable.
  always_comb begin
    if (r_state == WAIT) begin
      w_cur = r_snap;
    end else begin
      w_cur = w_in;
    end
  end

  // Control decode; gated by rst_n so req/hold fall the instant reset asserts.
  always_comb begin
    w_access   = w_cur.memread | w_cur.memwrite;
    w_misalign = is_misaligned(w_cur.ld, w_cur.st, w_cur.alures[1:0]);
    w_start    = 1'b0;
    w_misfire  = 1'b0;
    w_done     = 1'b0;
    w_timeout  = 1'b0;
    w_hold     = 1'b0;
    w_req      = 1'b0;
    if (!rst_n) begin
      w_req  = 1'b0;
      w_hold = 1'b0;
    end else if (r_state == IDLE) begin
      w_start   = w_access & ~w_misalign & ~i_dbg;
      w_misfire = w_access & w_misalign & ~i_dbg;
      w_req     = w_start;
      w_done    = w_start & bus.ack;
      w_hold    = w_start & ~bus.ack;
    end else begin
      w_req     = 1'b1;
      w_done    = ~i_dbg & bus.ack;
      w_timeout = ~i_dbg & ~bus.ack & (r_cnt == C_LAST);
      w_hold    = ~(w_done | w_timeout);
    end
  end

  lane_align u_lane (
    .i_a_lo       (w_cur.alures[1:0]),
    .i_memread    (w_cur.memread),
    .i_memwrite   (w_cur.memwrite),
    .i_loadcntrl  (w_cur.ld),
    .i_storecntrl (w_cur.st),
    .i_rs2        (w_cur.rs2),
    .i_rdata      (bus.rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_val   (w_load_val)
  );

  // Data-memory port drive.
  always_comb begin
    bus.req    = w_req;
    bus.we     = w_cur.memwrite;
    bus.addr   = {w_cur.alures[DW-1:2], 2'b00};
    bus.be     = w_be;
    bus.wdata  = w_wdata;
    o_mem_hold = w_hold;
  end

  // FSM and outstanding-cycle counter; the counter includes the issue cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (!i_dbg) begin
      if (r_state == IDLE) begin
        if (w_hold) begin
          r_state <= WAIT;
          r_cnt   <= C_ONE;
        end else begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      end else if (w_done | w_timeout) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + C_ONE;
      end
    end
  end

  // Capture the EX/MEM set while idle so WAIT can replay it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap <= '0;
    end else if (r_state == IDLE) begin
      r_snap <= w_in;
    end
  end

  // MEM/WB register set and error pulses; frozen while dbg is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd           <= 5'd0;
      r_regwrite     <= 1'b0;
      r_memread      <= 1'b0;
      r_wb_res       <= '0;
      r_misalign_err <= 1'b0;
      r_bus_err      <= 1'b0;
    end else if (!i_dbg) begin
      r_misalign_err <= w_misfire;
      r_bus_err      <= w_timeout;
      if (w_hold) begin
        r_rd       <= 5'd0;
        r_regwrite <= 1'b0;
        r_memread  <= 1'b0;
      end else if (w_done) begin
        r_rd       <= w_cur.rd;
        r_regwrite <= w_cur.regwrite & ~w_cur.memwrite;
        r_memread  <= w_cur.memread;
        r_wb_res   <= w_cur.memread ? w_load_val : w_cur.alures;
      end else if (w_timeout | w_misfire) begin
        r_rd       <= w_cur.rd;
        r_regwrite <= 1'b0;
        r_memread  <= 1'b0;
        r_wb_res   <= w_cur.alures;
      end else begin
        r_rd       <= w_cur.rd;
        r_regwrite <= w_cur.regwrite;
        r_memread  <= 1'b0;
        r_wb_res   <= w_cur.alures;
      end
    end
  end

  assign o_mem_wb_rd       = r_rd;
  assign o_mem_wb_regwrite = r_regwrite;
  assign o_mem_wb_memread  = r_memread;
  assign o_wb_res          = r_wb_res;
  assign o_misalign_err    = r_misalign_err;
  assign o_bus_err         = r_bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a MEM/WB scoreboard queue.
module tb_mem_access_stage;

  localparam int TO = 8;
  localparam logic [4:0] LB = 5'b00001, LW = 5'b00100, LHU = 5'b10000, LD0 = 5'b00000;
  localparam logic [2:0] SH = 3'b010, SW = 3'b100, ST0 = 3'b000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dbg, memread, memwrite, regwrite;
  logic [4:0]  rd, ldc;
  logic [2:0]  stc;
  logic [31:0] alures, rs2;
  logic        o_hold, o_rw, o_mr, o_mis, o_berr;
  logic [4:0]  o_rd;
  logic [31:0] o_res;

  typedef struct packed {
    logic [38:0] val;
    logic [38:0] mask;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int hold_cnt;

  always #5 clk = ~clk;

  mem_access_stage_if #(.XLEN(32)) bus ();

  mem_access_stage #(.TIMEOUT_CYC(TO), .XLEN(32)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_dbg               (dbg),
    .i_ex_mem_memread    (memread),
    .i_ex_mem_memwrite   (memwrite),
    .i_ex_mem_regwrite   (regwrite),
    .i_ex_mem_rd         (rd),
    .i_ex_mem_alures     (alures),
    .i_ex_mem_dout_rs2   (rs2),
    .i_ex_mem_loadcntrl  (ldc),
    .i_ex_mem_storecntrl (stc),
    .bus                 (bus),
    .o_mem_hold          (o_hold),
    .o_mem_wb_rd         (o_rd),
    .o_mem_wb_regwrite   (o_rw),
    .o_mem_wb_memread    (o_mr),
    .o_wb_res            (o_res),
    .o_misalign_err      (o_mis),
    .o_bus_err           (o_berr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic mr, input logic mw, input logic rw, input logic [4:0] d,
                           input logic [31:0] a, input logic [31:0] s,
                           input logic [4:0] l, input logic [2:0] st);
    memread = mr; memwrite = mw; regwrite = rw; rd = d;
    alures = a; rs2 = s; ldc = l; stc = st;
  endtask

  // cmr/cres select whether memread and WB_res take part in the comparison.
  task automatic push_wb(input logic [4:0] d, input logic rw, input logic mr, input logic [31:0] res,
                         input logic cmr, input logic cres);
    exp_t e;
    e.val  = {d, rw, mr, res};
    e.mask = {5'h1F, 1'b1, cmr, {32{cres}}};
    sb_q.push_back(e);
  endtask

  task automatic pop_wb(input string tag);
    exp_t e;
    logic [38:0] obs;
    obs = {o_rd, o_rw, o_mr, o_res};
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=no_entry expected=queued_entry", tag);
    end else begin
      e = sb_q.pop_front();
      check(tag, 64'(obs & e.mask), 64'(e.val & e.mask));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    dbg = 1'b0; bus.ack = 1'b0; bus.rdata = 32'h0;
    set_instr(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, LD0, ST0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 64'(bus.req), 64'd0);
    check("rst_hold", 64'(o_hold), 64'd0);
    check("rst_wb", 64'({o_rd, o_rw, o_mr, o_res}), 64'd0);
    check("rst_errs", 64'({o_mis, o_berr}), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // sw with zero-wait ack
    @(negedge clk);
    set_instr(1'b0, 1'b1, 1'b1, 5'd3, 32'h100, 32'hDEADBEEF, LD0, SW);
    bus.ack = 1'b1;
    push_wb(5'd3, 1'b0, 1'b0, 32'h100, 1'b1, 1'b0);
    #1;
    check("t1_req", 64'(bus.req), 64'd1);
    check("t1_we", 64'(bus.we), 64'd1);
    check("t1_addr", 64'(bus.addr), 64'h100);
    check("t1_be", 64'(bus.be), 64'hF);
    check("t1_wdata", 64'(bus.wdata), 64'hDEADBEEF);
    check("t1_hold", 64'(o_hold), 64'd0);
    @(posedge clk); #1;
    pop_wb("t1_wb");

    // lb with ack three cycles after the request
    hold_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        set_instr(1'b1, 1'b0, 1'b1, 5'd5, 32'h103, 32'h0, LB, ST0);
        bus.rdata = 32'h80FF_FF00;
        push_wb(5'd5, 1'b1, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b1);
      end
      bus.ack = (c == 3);
      #1;
      if (o_hold) hold_cnt++;
      check("t2_req", 64'(bus.req), 64'd1);
      check("t2_addr_be", 64'({bus.addr, bus.be}), 64'({32'h100, 4'hF}));
      @(posedge clk); #1;
      if (c < 3) check("t2_bubble", 64'({o_rw, o_mr}), 64'd0);
      else pop_wb("t2_wb");
    end
    check("t2_hold_cycles", 64'(hold_cnt), 64'd3);

    // sh then lhu at 0x202
    @(negedge clk);
    bus.ack = 1'b1;
    set_instr(1'b0, 1'b1, 1'b1, 5'd6, 32'h202, 32'h0000_ABCD, LD0, SH);
    push_wb(5'd6, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    check("t3_sh_be", 64'(bus.be), 64'b1100);
    check("t3_sh_wdata", 64'(bus.wdata), 64'hABCD_ABCD);
    check("t3_sh_addr", 64'(bus.addr), 64'h200);
    @(posedge clk); #1;
    pop_wb("t3_sh_wb");
    @(negedge clk);
    bus.rdata = 32'hABCD_0000;
    set_instr(1'b1, 1'b0, 1'b1, 5'd6, 32'h202, 32'h0, LHU, ST0);
    push_wb(5'd6, 1'b1, 1'b1, 32'h0000_ABCD, 1'b1, 1'b1);
    #1;
    check("t3_lhu_hold", 64'(o_hold), 64'd0);
    @(posedge clk); #1;
    pop_wb("t3_lhu_wb");

    // misaligned lw
    @(negedge clk);
    bus.ack = 1'b0;
    set_instr(1'b1, 1'b0, 1'b1, 5'd7, 32'h101, 32'h0, LW, ST0);
    push_wb(5'd7, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check("t4_req", 64'(bus.req), 64'd0);
    check("t4_hold", 64'(o_hold), 64'd0);
    @(posedge clk); #1;
    check("t4_mis_pulse", 64'(o_mis), 64'd1);
    pop_wb("t4_wb");
    // ALU op with a stray ack while idle
    @(negedge clk);
    bus.ack = 1'b1;
    set_instr(1'b0, 1'b0, 1'b1, 5'd9, 32'h44, 32'h0, LD0, ST0);
    push_wb(5'd9, 1'b1, 1'b0, 32'h44, 1'b1, 1'b1);
    #1;
    check("t4_stray_req", 64'(bus.req), 64'd0);
    @(posedge clk); #1;
    check("t4_mis_clear", 64'(o_mis), 64'd0);
    pop_wb("t4_alu_wb");

    // lw that is never acknowledged
    hold_cnt = 0;
    for (int c = 0; c < TO; c++) begin
      @(negedge clk);
      if (c == 0) begin
        set_instr(1'b1, 1'b0, 1'b1, 5'd4, 32'h300, 32'h0, LW, ST0);
        push_wb(5'd4, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      end
      bus.ack = 1'b0;
      #1;
      if (o_hold) hold_cnt++;
      check("t5_req", 64'(bus.req), 64'd1);
      @(posedge clk); #1;
      if (c < TO - 1) begin
        check("t5_no_err", 64'(o_berr), 64'd0);
        check("t5_bubble", 64'({o_rw, o_mr}), 64'd0);
      end else begin
        check("t5_bus_err", 64'(o_berr), 64'd1);
        pop_wb("t5_wb");
      end
    end
    check("t5_hold_cycles", 64'(hold_cnt), 64'd7);
    @(negedge clk);
    set_instr(1'b0, 1'b0, 1'b1, 5'd12, 32'h88, 32'h0, LD0, ST0);
    push_wb(5'd12, 1'b1, 1'b0, 32'h88, 1'b1, 1'b1);
    #1;
    check("t5_idle_req", 64'({bus.req, o_hold}), 64'd0);
    @(posedge clk); #1;
    check("t5_err_clear", 64'(o_berr), 64'd0);
    pop_wb("t5_alu_wb");

    // async reset in the middle of WAIT
    @(negedge clk);
    set_instr(1'b1, 1'b0, 1'b1, 5'd13, 32'h400, 32'h0, LW, ST0);
    #1;
    check("t6_hold_issue", 64'(o_hold), 64'd1);
    @(negedge clk); #1;
    check("t6_req_wait", 64'(bus.req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_req_drop", 64'(bus.req), 64'd0);
    check("t6_hold_drop", 64'(o_hold), 64'd0);
    check("t6_wb_clear", 64'({o_rw, o_mr, o_mis, o_berr}), 64'd0);
    @(posedge clk); #1;
    check("t6_req_in_rst", 64'(bus.req), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_instr(1'b0, 1'b0, 1'b1, 5'd10, 32'h1234, 32'h0, LD0, ST0);
    push_wb(5'd10, 1'b1, 1'b0, 32'h1234, 1'b1, 1'b1);
    @(posedge clk); #1;
    pop_wb("t6_addi_wb");
    check("t6_no_pulses", 64'({o_mis, o_berr}), 64'd0);

    // debug freeze keeps MEM/WB unchanged
    @(negedge clk);
    dbg = 1'b1;
    set_instr(1'b0, 1'b0, 1'b1, 5'd11, 32'h55, 32'h0, LD0, ST0);
    #1;
    check("dbg_req", 64'(bus.req), 64'd0);
    @(posedge clk); #1;
    check("dbg_freeze", 64'({o_rd, o_res}), 64'({5'd10, 32'h1234}));
    @(negedge clk);
    dbg = 1'b0;
    push_wb(5'd11, 1'b1, 1'b0, 32'h55, 1'b1, 1'b1);
    @(posedge clk); #1;
    pop_wb("dbg_release_wb");

    check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
